mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store sequencer that sits directly downstream of the CPU's memory address decoder. It consumes the decoded physical address, one-hot bank enable and bank index, and drives the three memory banks: data/stack RAM, VGA text RAM and MMIO. It generates byte-lane write enables, extracts and extends loaded bytes and halfwords, stalls the pipeline across the synchronous bank read latency, and flags invalid, misaligned and conflicting accesses.

## Interface
- RD_LAT, 1, bank read latency in cycles from bank_en to valid bank_rdataN; legal range 1..3
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory operation presented this cycle
- mem_read  in  1  load request
- mem_write  in  1  store request
- phys_addr  in  13  decoded physical byte address
- mem_en  in  3  decoded one-hot bank enable: bit0 data RAM, bit1 VGA, bit2 MMIO
- mem_bank  in  2  decoded bank index: 0, 1 or 2
- invalid_addr  in  1  decoder found no valid region
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- sign_ext  in  1  sign-extend loads (1) or zero-extend them (0)
- wr_data  in  32  store data, right-aligned
- stall  out  1  hold the CPU pipeline
- rd_data  out  32  extended load result
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high
- exc  out  1  one-cycle exception pulse
- exc_code  out  2  01 invalid region, 10 misaligned, 11 read and write both set
- bank_addr  out  11  word address, phys_addr[12:2]
- bank_en  out  3  one-hot bank strobe
- bank_we  out  4  byte-lane write enables
- bank_wdata  out  32  lane-replicated store data
- bank_rdata0, bank_rdata1, bank_rdata2  in  32 each  read data returned by banks 0, 1 and 2

## Operation
- States: IDLE, ISSUE, WAIT, DONE. A request is accepted only in IDLE when req_valid=1. req_valid is ignored in every other state; the requester holds its inputs while stall=1.
- Error check at acceptance, first match wins:
  - mem_read and mem_write both 1 → code 11.
  - invalid_addr=1, or mem_en not one-hot → code 01.
  - half access with phys_addr[0]=1, or word access with phys_addr[1:0]≠0 → code 10.
  - On any error: no bank access, no stall, state stays IDLE.
- Store (no error): bank_addr, bank_en, bank_we and bank_wdata are registered and driven for exactly one cycle. State stays IDLE.
  - Byte lane n = phys_addr[1:0]; lane 0 is bits 7:0 (little-endian).
  - Byte store: bank_we = 1<<n, bank_wdata = {4{wr_data[7:0]}}.
  - Half store: bank_we = 0011 or 1100, bank_wdata = {2{wr_data[15:0]}}.
  - Word store: bank_we = 1111, bank_wdata = wr_data.
- Load (no error): latch phys_addr[1:0], size, sign_ext and mem_bank, then go to ISSUE.
  - ISSUE: bank_en = latched one-hot, bank_we = 0 → go to WAIT.
  - WAIT: lasts RD_LAT cycles, counted by a 2-bit counter. On its last cycle, capture bank_rdata[latched bank], shift it right by 8·offset, extend from bit 7 or bit 15 per size and sign_ext, and store it in rd_data → go to DONE.
  - DONE: rd_valid=1 → go to IDLE.
- stall = !rst && ((state==IDLE && req_valid && mem_read && no error) || state==ISSUE || state==WAIT).
- rd_data holds its last value until the next load completes.

## Timing
- Reset value of every output is 0: stall, rd_data, rd_valid, exc, exc_code, bank_addr, bank_en, bank_we, bank_wdata. The state returns to IDLE.
- Store accepted in cycle T: bank strobe in cycle T+1 only; stall never asserts.
- Error accepted in cycle T: exc=1 with exc_code in cycle T+1 only.
- Load accepted in cycle T:
  - stall=1 in cycles T through T+1+RD_LAT.
  - bank_en=1 in cycle T+1.
  - rd_valid=1 in cycle T+2+RD_LAT, with stall=0 in that cycle.
  - With RD_LAT=1 the load-to-use latency is 3 cycles.
- Back-to-back operations: a new request can be accepted in the DONE cycle's successor, i.e. the cycle after rd_valid. A store in IDLE can be accepted every cycle.
- rst asserted mid-load, in any state: the next edge goes to IDLE with all outputs 0. The in-flight load is dropped and rd_valid is never pulsed for it.

## Test plan
- Word store: phys_addr=0x010, mem_en=001, wr_data=0xDEADBEEF, cycle T → in T+1, bank_addr=0x004, bank_en=001, bank_we=1111, bank_wdata=0xDEADBEEF; stall stays 0.
- Byte store: phys_addr=0x013, wr_data=0x000000A5 → bank_we=1000, bank_wdata=0xA5A5A5A5.
- Signed byte load, RD_LAT=1: phys_addr=0x002, sign_ext=1, bank_rdata0=0x12F03456 → stall high for 3 cycles, then rd_valid=1 with rd_data=0xFFFFFFF0. Repeat with sign_ext=0 → rd_data=0x000000F0.
- Error cases, no bank activity in any of them:
  - Half load at phys_addr=0x005 → exc=1, exc_code=10.
  - invalid_addr=1 → exc_code=01.
  - mem_read=mem_write=1 → exc_code=11.
- RD_LAT=3, VGA half load at phys_addr=0x006, bank_rdata1=0xBEEF1234 → rd_valid in T+5, rd_data=0xFFFFBEEF.
- rst pulsed during the WAIT of a load → all outputs 0 on the next edge; no rd_valid follows; a following store executes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the address decoder and the data, VGA and MMIO banks.
// Stores strobe a bank for one cycle; loads stall through ISSUE/WAIT and return extended data in DONE.
module mem_access_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [12:0] phys_addr,
  input  logic [2:0]  mem_en,
  input  logic [1:0]  mem_bank,
  input  logic        invalid_addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        exc,
  output logic [1:0]  exc_code,
  output logic [10:0] bank_addr,
  output logic [2:0]  bank_en,
  output logic [3:0]  bank_we,
  output logic [31:0] bank_wdata,
  input  logic [31:0] bank_rdata0,
  input  logic [31:0] bank_rdata1,
  input  logic [31:0] bank_rdata2
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  bank_q, bank_d;
  logic [10:0] bank_addr_q, bank_addr_d;
  logic [2:0]  bank_en_q, bank_en_d;
  logic [3:0]  bank_we_q, bank_we_d;
  logic [31:0] bank_wdata_q, bank_wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        exc_q, exc_d;
  logic [1:0]  exc_code_q, exc_code_d;

  logic        onehot;
  logic        accept;
  logic        ld_go;
  logic        st_go;
  logic [1:0]  err_code;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [31:0] sel_rdata;
  logic [31:0] shifted;
  logic [31:0] ext_rdata;

  // Request decode; error priority is read+write, then region, then alignment.
  always_comb begin
    onehot   = (mem_en == 3'b001) || (mem_en == 3'b010) || (mem_en == 3'b100);
    err_code = 2'b00;
    if (mem_read && mem_write) begin
      err_code = 2'b11;
    end else if (invalid_addr || !onehot) begin
      err_code = 2'b01;
    end else if ((size == 2'b01 && phys_addr[0]) || (size[1] && phys_addr[1:0] != 2'b00)) begin
      err_code = 2'b10;
    end
    accept = (state_q == IDLE) && req_valid && (mem_read || mem_write);
    ld_go  = accept && (err_code == 2'b00) && mem_read;
    st_go  = accept && (err_code == 2'b00) && mem_write;
  end

  always_comb begin
    case (size)
      2'b00: begin
        st_we    = 4'b0001 << phys_addr[1:0];
        st_wdata = {4{wr_data[7:0]}};
      end
      2'b01: begin
        st_we    = phys_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wr_data[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = wr_data;
      end
    endcase
  end

  always_comb begin
    case (bank_q)
      2'd0:    sel_rdata = bank_rdata0;
      2'd1:    sel_rdata = bank_rdata1;
      default: sel_rdata = bank_rdata2;
    endcase
    shifted = sel_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ext_rdata = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ext_rdata = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: ext_rdata = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    sext_d       = sext_q;
    bank_d       = bank_q;
    bank_addr_d  = 11'd0;
    bank_en_d    = 3'd0;
    bank_we_d    = 4'd0;
    bank_wdata_d = 32'd0;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    exc_d        = 1'b0;
    exc_code_d   = 2'b00;

    case (state_q)
      IDLE: begin
        if (accept && err_code != 2'b00) begin
          exc_d      = 1'b1;
          exc_code_d = err_code;
        end else if (st_go) begin
          bank_addr_d  = phys_addr[12:2];
          bank_en_d    = mem_en;
          bank_we_d    = st_we;
          bank_wdata_d = st_wdata;
        end else if (ld_go) begin
          // Bank strobe is registered here so it is visible during ISSUE.
          bank_addr_d = phys_addr[12:2];
          bank_en_d   = mem_en;
          off_d       = phys_addr[1:0];
          size_d      = size;
          sext_d      = sign_ext;
          bank_d      = mem_bank;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 2'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          rd_data_d  = ext_rdata;
          rd_valid_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      sext_q       <= 1'b0;
      bank_q       <= 2'd0;
      bank_addr_q  <= 11'd0;
      bank_en_q    <= 3'd0;
      bank_we_q    <= 4'd0;
      bank_wdata_q <= 32'd0;
      rd_data_q    <= 32'd0;
      rd_valid_q   <= 1'b0;
      exc_q        <= 1'b0;
      exc_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      bank_q       <= bank_d;
      bank_addr_q  <= bank_addr_d;
      bank_en_q    <= bank_en_d;
      bank_we_q    <= bank_we_d;
      bank_wdata_q <= bank_wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      exc_q        <= exc_d;
      exc_code_q   <= exc_code_d;
    end
  end

  assign stall      = !rst && (ld_go || state_q == ISSUE || state_q == WAIT);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign exc        = exc_q;
  assign exc_code   = exc_code_q;
  assign bank_addr  = bank_addr_q;
  assign bank_en    = bank_en_q;
  assign bank_we    = bank_we_q;
  assign bank_wdata = bank_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share the request inputs,
// a reference model queues expected bank/response events per instance and a negedge monitor checks them.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, mem_read, mem_write, invalid_addr, sign_ext;
  logic [12:0] phys_addr;
  logic [2:0]  mem_en;
  logic [1:0]  mem_bank, size;
  logic [31:0] wr_data;
  logic [31:0] bk [2][3];

  logic        o_stall [2];
  logic [31:0] o_rd_data [2];
  logic        o_rd_valid [2];
  logic        o_exc [2];
  logic [1:0]  o_exc_code [2];
  logic [10:0] o_bank_addr [2];
  logic [2:0]  o_bank_en [2];
  logic [3:0]  o_bank_we [2];
  logic [31:0] o_bank_wdata [2];

  mem_access_ctrl #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .phys_addr(phys_addr), .mem_en(mem_en), .mem_bank(mem_bank), .invalid_addr(invalid_addr),
    .size(size), .sign_ext(sign_ext), .wr_data(wr_data),
    .stall(o_stall[0]), .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]), .exc(o_exc[0]),
    .exc_code(o_exc_code[0]), .bank_addr(o_bank_addr[0]), .bank_en(o_bank_en[0]),
    .bank_we(o_bank_we[0]), .bank_wdata(o_bank_wdata[0]),
    .bank_rdata0(bk[0][0]), .bank_rdata1(bk[0][1]), .bank_rdata2(bk[0][2])
  );

  mem_access_ctrl #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
    .phys_addr(phys_addr), .mem_en(mem_en), .mem_bank(mem_bank), .invalid_addr(invalid_addr),
    .size(size), .sign_ext(sign_ext), .wr_data(wr_data),
    .stall(o_stall[1]), .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]), .exc(o_exc[1]),
    .exc_code(o_exc_code[1]), .bank_addr(o_bank_addr[1]), .bank_en(o_bank_en[1]),
    .bank_we(o_bank_we[1]), .bank_wdata(o_bank_wdata[1]),
    .bank_rdata0(bk[1][0]), .bank_rdata1(bk[1][1]), .bank_rdata2(bk[1][2])
  );

  typedef struct {
    logic        rd, wr;
    logic [12:0] addr;
    logic [2:0]  en;
    logic [1:0]  bank;
    logic        inv;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] rv0, rv1;
  } op_t;

  typedef struct {
    int          cyc;
    logic [2:0]  en;
    logic [3:0]  we;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        rv;
    logic [31:0] rdat;
    logic        exc;
    logic [1:0]  code;
  } ev_t;

  ev_t q [2][$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  stall_lo [2] = '{1, 1};
  int  stall_hi [2] = '{0, 0};
  bit  mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] model_err(input op_t o);
    if (o.rd && o.wr) return 2'b11;
    if (o.inv || !(o.en == 3'd1 || o.en == 3'd2 || o.en == 3'd4)) return 2'b01;
    if (o.size == 2'd1 && (o.addr % 2) != 0) return 2'b10;
    if (o.size >= 2'd2 && (o.addr % 4) != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int sz, input bit sx);
    longint v;
    v = longint'(w) / (longint'(1) << (8 * off));
    if (sz == 0) begin
      v = v % 256;
      if (sx && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (sx && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  function automatic op_t mk(input bit rd, input bit wr, input logic [12:0] addr, input logic [2:0] en,
                             input logic [1:0] bank, input bit inv, input logic [1:0] sz, input bit sx,
                             input logic [31:0] wd, input logic [31:0] r0, input logic [31:0] r1);
    op_t o;
    o.rd = rd; o.wr = wr; o.addr = addr; o.en = en; o.bank = bank; o.inv = inv;
    o.size = sz; o.sext = sx; o.wdata = wd; o.rv0 = r0; o.rv1 = r1;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon_chk(input int i);
    ev_t e;
    bit  active, exp_st, ok;
    exp_st = (cyc >= stall_lo[i]) && (cyc <= stall_hi[i]);
    chk($sformatf("stall inst%0d cyc%0d", i, cyc), 32'(o_stall[i]), 32'(exp_st));
    while (q[i].size() > 0 && q[i][0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_event inst%0d: event due in cycle %0d never appeared", i, q[i][0].cyc);
      q[i].delete(0);
    end
    active = (o_bank_en[i] != 3'd0) || (o_rd_valid[i] === 1'b1) || (o_exc[i] === 1'b1);
    if (active) begin
      checks++;
      if (q[i].size() == 0 || q[i][0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_output inst%0d cyc%0d: en=%b rv=%b exc=%b, expected no activity",
                 i, cyc, o_bank_en[i], o_rd_valid[i], o_exc[i]);
      end else begin
        e = q[i][0];
        q[i].delete(0);
        ok = (o_bank_en[i] === e.en) && (o_bank_we[i] === e.we) && (o_bank_addr[i] === e.addr) &&
             (!e.chk_wdata || o_bank_wdata[i] === e.wdata) && (o_rd_valid[i] === e.rv) &&
             (!e.rv || o_rd_data[i] === e.rdat) && (o_exc[i] === e.exc) &&
             (!e.exc || o_exc_code[i] === e.code);
        if (!ok) begin
          errors++;
          $display("FAIL event inst%0d cyc%0d: got en=%b we=%b addr=%h wdata=%h rv=%b rdata=%h exc=%b code=%b; expected en=%b we=%b addr=%h wdata=%h rv=%b rdata=%h exc=%b code=%b",
                   i, cyc, o_bank_en[i], o_bank_we[i], o_bank_addr[i], o_bank_wdata[i], o_rd_valid[i],
                   o_rd_data[i], o_exc[i], o_exc_code[i], e.en, e.we, e.addr, e.wdata, e.rv, e.rdat, e.exc, e.code);
        end
      end
    end else begin
      chk($sformatf("idle_we inst%0d cyc%0d", i, cyc), 32'(o_bank_we[i]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_chk(0);
      mon_chk(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_banks();
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 3; b++)
        bk[i][b] = $urandom;
  endtask

  task automatic zero_check(input int i, input string tag);
    chk({tag, " stall"},      32'(o_stall[i]),      32'd0);
    chk({tag, " rd_data"},    o_rd_data[i],         32'd0);
    chk({tag, " rd_valid"},   32'(o_rd_valid[i]),   32'd0);
    chk({tag, " exc"},        32'(o_exc[i]),        32'd0);
    chk({tag, " exc_code"},   32'(o_exc_code[i]),   32'd0);
    chk({tag, " bank_addr"},  32'(o_bank_addr[i]),  32'd0);
    chk({tag, " bank_en"},    32'(o_bank_en[i]),    32'd0);
    chk({tag, " bank_we"},    32'(o_bank_we[i]),    32'd0);
    chk({tag, " bank_wdata"}, o_bank_wdata[i],      32'd0);
  endtask

  // Issues one request in the current cycle; loads also play the bank side and
  // wait until both instances are idle again. rst_at>0 pulses rst in cycle T+rst_at.
  task automatic do_op(input op_t o, input int rst_at);
    int         t;
    logic [1:0] code;
    ev_t        e;
    int         off, sz;
    logic [31:0] rv [2];
    t    = cyc;
    code = model_err(o);
    off  = int'(o.addr % 4);
    sz   = (o.size >= 2'd2) ? 2 : int'(o.size);
    rv[0] = o.rv0;
    rv[1] = o.rv1;
    req_valid = 1'b1; mem_read = o.rd; mem_write = o.wr; phys_addr = o.addr; mem_en = o.en;
    mem_bank = o.bank; invalid_addr = o.inv; size = o.size; sign_ext = o.sext; wr_data = o.wdata;
    rand_banks();
    for (int i = 0; i < 2; i++) begin
      e = '{default: '0};
      e.cyc = t + 1;
      if (code != 2'b00) begin
        e.exc  = 1'b1;
        e.code = code;
        q[i].push_back(e);
      end else if (o.wr) begin
        e.en        = o.en;
        e.addr      = 11'(o.addr / 4);
        e.chk_wdata = 1'b1;
        if (sz == 0) begin
          e.we    = 4'(1 << off);
          e.wdata = (o.wdata % 256) * 32'h01010101;
        end else if (sz == 1) begin
          e.we    = 4'(3 << off);
          e.wdata = (o.wdata % 65536) * 32'h00010001;
        end else begin
          e.we    = 4'hF;
          e.wdata = o.wdata;
        end
        q[i].push_back(e);
      end else begin
        e.en   = o.en;
        e.addr = 11'(o.addr / 4);
        q[i].push_back(e);
        e      = '{default: '0};
        e.cyc  = t + 2 + lat_of(i);
        e.rv   = 1'b1;
        e.rdat = model_load(rv[i], off, sz, o.sext);
        q[i].push_back(e);
        stall_lo[i] = t;
        stall_hi[i] = t + 1 + lat_of(i);
      end
    end
    step();
    if (code == 2'b00 && o.rd) begin
      for (int k = 1; k <= 5; k++) begin
        req_valid = 1'b0;
        if (rst_at == k) begin
          rst = 1'b1;
          for (int i = 0; i < 2; i++) begin
            for (int j = q[i].size() - 1; j >= 0; j--)
              if (q[i][j].cyc > t + k) q[i].delete(j);
            if (stall_hi[i] > t + k - 1) stall_hi[i] = t + k - 1;
          end
          step();
          rst = 1'b0;
          zero_check(0, "midload_rst lat1");
          zero_check(1, "midload_rst lat3");
          return;
        end
        rand_banks();
        for (int i = 0; i < 2; i++)
          if (k == 1 + lat_of(i)) bk[i][o.bank] = rv[i];
        step();
      end
    end
  endtask

  task automatic rand_op();
    op_t        o;
    int         b, kind, e;
    logic [2:0] bad;
    b = $urandom_range(0, 2);
    o = mk(1'b0, 1'b0, 13'($urandom), 3'(1 << b), 2'(b), 1'b0, 2'($urandom_range(0, 3)),
           1'($urandom), $urandom, $urandom, $urandom);
    if (o.size == 2'd1) o.addr[0] = 1'b0;
    if (o.size[1]) o.addr[1:0] = 2'b00;
    kind = $urandom_range(0, 9);
    if (kind < 4) begin
      o.wr = 1'b1;
    end else if (kind < 8) begin
      o.rd = 1'b1;
    end else if (kind == 8) begin
      o.rd = 1'($urandom);
      o.wr = !o.rd;
      e = $urandom_range(0, 3);
      case (e)
        0: begin o.rd = 1'b1; o.wr = 1'b1; end
        1: o.inv = 1'b1;
        2: begin
          do bad = 3'($urandom); while (bad == 3'd1 || bad == 3'd2 || bad == 3'd4);
          o.en = bad;
        end
        default: begin
          if (o.size == 2'd0) o.size = 2'd1;
          o.addr[0] = 1'b1;
        end
      endcase
    end else begin
      req_valid = 1'b0;
      step();
      return;
    end
    do_op(o, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; phys_addr = '0; mem_en = '0;
    mem_bank = '0; invalid_addr = 1'b0; size = '0; sign_ext = 1'b0; wr_data = '0;
    rand_banks();
    step();
    step();
    zero_check(0, "reset lat1");
    zero_check(1, "reset lat3");
    mon_on = 1'b1;
    rst = 1'b0;
    step();

    do_op(mk(1'b0, 1'b1, 13'h010, 3'b001, 2'd0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0), 0);
    do_op(mk(1'b0, 1'b1, 13'h013, 3'b001, 2'd0, 1'b0, 2'b00, 1'b0, 32'h000000A5, 32'h0, 32'h0), 0);
    do_op(mk(1'b1, 1'b0, 13'h002, 3'b001, 2'd0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h12F03456, 32'h12F03456), 0);
    do_op(mk(1'b1, 1'b0, 13'h002, 3'b001, 2'd0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h12F03456, 32'h12F03456), 0);
    do_op(mk(1'b1, 1'b0, 13'h005, 3'b001, 2'd0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0), 0);
    do_op(mk(1'b1, 1'b0, 13'h004, 3'b001, 2'd0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0), 0);
    do_op(mk(1'b1, 1'b1, 13'h008, 3'b001, 2'd0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0), 0);
    do_op(mk(1'b1, 1'b0, 13'h006, 3'b010, 2'd1, 1'b0, 2'b01, 1'b1, 32'h0, 32'hBEEF1234, 32'hBEEF1234), 0);
    do_op(mk(1'b1, 1'b0, 13'h020, 3'b100, 2'd2, 1'b0, 2'b10, 1'b0, 32'h0, 32'h11223344, 32'h55667788), 2);
    do_op(mk(1'b0, 1'b1, 13'h1FFC, 3'b100, 2'd2, 1'b0, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 32'h0), 0);
    req_valid = 1'b0;
    step();

    for (int n = 0; n < 300; n++) rand_op();

    req_valid = 1'b0;
    for (int n = 0; n < 8; n++) step();
    chk("leftover_events lat1", 32'(q[0].size()), 32'd0);
    chk("leftover_events lat3", 32'(q[1].size()), 32'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
